// File: rtl/pulse_burst_controller.sv
// pulse_burst_controller
//   Emits a burst of pulses on signal_o. Each pulse is high_len cycles high
//   followed by low_len cycles low. The burst configuration is latched when
//   the burst starts, so inputs may change freely while a burst is running.
//   A length of zero is treated as one cycle.
//
// Optional feature (macro PULSE_BURST_REPEAT_EN):
//   Adds repeat_i. When repeat_i is high in DONE, the next burst is launched
//   immediately, using freshly latched configuration.
//
// Ports
//   clock_i      system clock, rising edge
//   reset_ni     asynchronous reset, active low
//   start_i      burst request, sampled only in IDLE
//   abort_i      synchronous cancel, returns to IDLE
//   repeat_i     (PULSE_BURST_REPEAT_EN only) chain another burst from DONE
//   high_len_i   high-phase length in cycles
//   low_len_i    low-phase length in cycles
//   pulses_i     number of pulses in the burst
//   signal_o     registered pulse line
//   busy_o       high during the HIGH and LOW phases
//   done_o       one-cycle strobe at burst completion
//   pulse_idx_o  index of the current pulse
//
// state | meaning
// IDLE  | waiting for start_i
// HIGH  | pulse line high, counting the high phase
// LOW   | pulse line low, counting the low phase
// DONE  | completion strobe cycle
module pulse_burst_controller #(
  parameter int CNT_W = 8,
  parameter int N_W   = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
`ifdef PULSE_BURST_REPEAT_EN
  input  logic             repeat_i,
`endif
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [N_W-1:0]   pulses_i,
  output logic             signal_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [N_W-1:0]   pulse_idx_o
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_e;

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [N_W-1:0]   ONE_N = N_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;
  logic [N_W-1:0]   pulses_q;
  logic [N_W-1:0]   idx_q;
  logic             signal_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] high_cl;
  logic [CNT_W-1:0] low_cl;
  logic             repeat_req;

  assign high_cl = (high_len_i == '0) ? ONE_C : high_len_i;
  assign low_cl  = (low_len_i == '0) ? ONE_C : low_len_i;

`ifdef PULSE_BURST_REPEAT_EN
  assign repeat_req = repeat_i;
`else
  assign repeat_req = 1'b0;
`endif

  // The phase counter holds "remaining edges minus one": a phase loaded with
  // N-1 exits on the edge that finds it at zero, giving exactly N cycles.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      pulses_q <= '0;
      idx_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if ((state_q == S_IDLE && start_i) || (state_q == S_DONE && repeat_req)) begin
            high_q   <= high_cl;
            low_q    <= low_cl;
            pulses_q <= pulses_i;
            idx_q    <= '0;
            if (pulses_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_HIGH;
              cnt_q    <= high_cl - ONE_C;
              signal_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            idx_q   <= '0;
          end
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            state_q  <= S_LOW;
            cnt_q    <= low_q - ONE_C;
            signal_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE_C;
          end
        end
        S_LOW: begin
          if (cnt_q == '0) begin
            if (idx_q == pulses_q - ONE_N) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_HIGH;
              idx_q    <= idx_q + ONE_N;
              cnt_q    <= high_q - ONE_C;
              signal_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - ONE_C;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          signal_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign signal_o    = signal_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_idx_o = idx_q;

endmodule

// File: tb/tb_pulse_burst_controller.sv
module tb_pulse_burst_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rep = 1'b0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [3:0] pulses = '0;
  logic       signal_w;
  logic       busy_w;
  logic       done_w;
  logic [3:0] idx_w;

  int n_chk = 0;
  int n_bad = 0;

  // Expected {signal, busy, done, pulse_idx} per cycle after the accept edge.
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  pulse_burst_controller #(.CNT_W(8), .N_W(4)) dut (
    .clock_i    (clk),
    .reset_ni   (rst_n),
    .start_i    (start),
    .abort_i    (abort),
`ifdef PULSE_BURST_REPEAT_EN
    .repeat_i   (rep),
`endif
    .high_len_i (high_len),
    .low_len_i  (low_len),
    .pulses_i   (pulses),
    .signal_o   (signal_w),
    .busy_o     (busy_w),
    .done_o     (done_w),
    .pulse_idx_o(idx_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {signal_w, busy_w, done_w, idx_w};
  endfunction

  // Reference waveform: H cycles high, L cycles low per pulse, then one DONE
  // cycle (index still at the last pulse), then optionally one idle cycle.
  task automatic push_burst(input int h, input int l, input int n, input bit tail);
    int hc = (h == 0) ? 1 : h;
    int lc = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < hc; k++) exp_q.push_back({3'b110, 4'(p)});
      for (int k = 0; k < lc; k++) exp_q.push_back({3'b010, 4'(p)});
    end
    exp_q.push_back({3'b001, (n == 0) ? 4'd0 : 4'(n - 1)});
    if (tail) exp_q.push_back(7'd0);
  endtask

  // Starts a burst at the current negedge and checks every following cycle.
  // poke: cycle at which start is re-pulsed and the config scrambled.
  // abrt: cycle after whose check abort is raised for one edge.
  task automatic run(input string tag, input int h, input int l, input int n,
                     input int poke, input int abrt);
    int i = 1;
    int n_done = 0;
    logic [6:0] e;
    high_len = 8'(h);
    low_len  = 8'(l);
    pulses   = 4'(n);
    start    = 1'b1;
    exp_q.delete();
    push_burst(h, l, n, 1'b1);
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (done_w) n_done++;
      chk(tag, 32'(outs()), 32'(e));
      start = 1'b0;
      if (i == poke) begin
        start    = 1'b1;
        high_len = 8'd7;
        low_len  = 8'd5;
        pulses   = 4'd1;
      end
      if (i == abrt) begin
        abort = 1'b1;
        exp_q.delete();
        exp_q.push_back(7'd0);
      end
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      i++;
    end
    chk({tag, "_ndone"}, 32'(n_done), (abrt > 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: outputs stay cleared.
    start    = 1'b1;
    high_len = 8'd3;
    low_len  = 8'd2;
    pulses   = 4'd4;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", 32'(outs()), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_reset", 32'(outs()), 32'd0);
    end

    run("basic", 3, 2, 4, 0, 0);
    run("zero_len", 0, 0, 1, 0, 0);
    run("zero_pulses", 3, 2, 0, 0, 0);
    run("restart_ignored", 3, 2, 4, 5, 0);
    run("abort", 3, 2, 4, 0, 7);
    run("max_vals", 255, 1, 15, 0, 0);
    run("after_max", 1, 4, 3, 0, 0);

    // Asynchronous reset in the middle of a burst, between clock edges.
    high_len = 8'd3;
    low_len  = 8'd2;
    pulses   = 4'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(busy_w), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_async", 32'(outs()), 32'd0);

`ifdef PULSE_BURST_REPEAT_EN
    begin
      int i = 1;
      logic [6:0] e;
      rep      = 1'b1;
      high_len = 8'd1;
      low_len  = 8'd1;
      pulses   = 4'd2;
      start    = 1'b1;
      exp_q.delete();
      push_burst(1, 1, 2, 1'b0);
      push_burst(1, 1, 2, 1'b1);
      @(negedge clk);
      start = 1'b0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("repeat", 32'(outs()), 32'(e));
        if (i == 6) rep = 1'b0;
        @(negedge clk);
        i++;
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
